// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue sequencer: opcodes, FSM states
// and the opcode decoder that picks how the Bin operand is formed.
package alu_pkg;

  localparam int ALU_W    = 16;
  localparam int ALU_NREG = 8;

  localparam logic [4:0] OP_ADDI    = 5'b01000;
  localparam logic [4:0] OP_SUBI    = 5'b01001;
  localparam logic [4:0] OP_XORI    = 5'b01010;
  localparam logic [4:0] OP_ANDNI   = 5'b01011;
  localparam logic [4:0] OP_ROLI    = 5'b10100;
  localparam logic [4:0] OP_SLLI    = 5'b10101;
  localparam logic [4:0] OP_RORI    = 5'b10110;
  localparam logic [4:0] OP_SRLI    = 5'b10111;
  localparam logic [4:0] OP_BTR     = 5'b11001;
  localparam logic [4:0] OP_SHIFT_R = 5'b11010;
  localparam logic [4:0] OP_ARITH_R = 5'b11011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BSEL_SEXT  = 3'd0,
    BSEL_ZEXT  = 3'd1,
    BSEL_SHAMT = 3'd2,
    BSEL_RT    = 3'd3,
    BSEL_ZERO  = 3'd4
  } bsel_e;

  typedef struct packed {
    logic  legal;
    logic  r_fmt;      // Rd taken from [4:2] instead of [7:5]
    logic  use_funct;  // funct field forwarded to the ALU
    bsel_e bsel;
  } decode_t;

  function automatic decode_t decode_op(input logic [4:0] op);
    decode_t d;
    d = '{legal: 1'b1, r_fmt: 1'b0, use_funct: 1'b0, bsel: BSEL_ZERO};
    case (op)
      OP_ADDI, OP_SUBI:                   d.bsel = BSEL_SEXT;
      OP_XORI, OP_ANDNI:                  d.bsel = BSEL_ZEXT;
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: d.bsel = BSEL_SHAMT;
      OP_ARITH_R, OP_SHIFT_R: begin
        d.r_fmt     = 1'b1;
        d.use_funct = 1'b1;
        d.bsel      = BSEL_RT;
      end
      OP_BTR:                             d.r_fmt = 1'b1;
      default:                            d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two asynchronous operand read ports, one
// asynchronous debug read port and a single synchronous write port.
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_comb begin
      regs_d[gi] = regs_q[gi];
      if (we && (waddr == AW'(gi))) regs_d[gi] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q[gi] <= '0;
      else        regs_q[gi] <= regs_d[gi];
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer in front of the ALU: accepts an instruction, reads
// operands, drives the ALU for one cycle and writes the result back to Rd.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W,
  parameter int NREG   = ALU_NREG,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic [4:0]        alu_opcode,
  output logic [1:0]        alu_funct,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [1:0]        funct_q, funct_d;
  logic [DATA_W-1:0] ain_q, ain_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              illegal_q, illegal_d;

  logic              accept;
  logic              rf_we;
  decode_t           dec;
  logic [4:0]        imm5;
  logic [AW-1:0]     rs_addr, rt_addr;
  logic [DATA_W-1:0] rs_data, rt_data, bin_sel;

  assign dec     = decode_op(instr[15:11]);
  assign rs_addr = instr[8 +: AW];
  assign rt_addr = instr[5 +: AW];
  assign imm5    = instr[4:0];
  assign accept  = in_valid && in_ready;

  alu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (result_q),
    .raddr_a  (rs_addr),
    .rdata_a  (rs_data),
    .raddr_b  (rt_addr),
    .rdata_b  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && dec.legal) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    wb_valid = (state_q == ST_WB);
    rf_we    = (state_q == ST_WB);
  end

  // Operands are captured at acceptance; the previous writeback is already in the regfile.
  always_comb begin
    case (dec.bsel)
      BSEL_SEXT:  bin_sel = {{(DATA_W-5){imm5[4]}}, imm5};
      BSEL_ZEXT:  bin_sel = {{(DATA_W-5){1'b0}}, imm5};
      BSEL_SHAMT: bin_sel = {{(DATA_W-4){1'b0}}, imm5[3:0]};
      BSEL_RT:    bin_sel = rt_data;
      default:    bin_sel = '0;
    endcase
  end

  always_comb begin
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    ain_d     = ain_q;
    bin_d     = bin_q;
    rd_d      = rd_q;
    result_d  = result_q;
    illegal_d = 1'b0;
    if (accept) begin
      if (dec.legal) begin
        opcode_d = instr[15:11];
        funct_d  = dec.use_funct ? instr[1:0] : 2'b00;
        ain_d    = rs_data;
        bin_d    = bin_sel;
        rd_d     = dec.r_fmt ? instr[2 +: AW] : instr[5 +: AW];
      end else begin
        illegal_d = 1'b1;
      end
    end
    if (state_q == ST_ISSUE) result_d = alu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      funct_q   <= '0;
      ain_q     <= '0;
      bin_q     <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      ain_q     <= ain_d;
      bin_q     <= bin_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_opcode = opcode_q;
  assign alu_funct  = funct_q;
  assign alu_ain    = ain_q;
  assign alu_bin    = bin_q;
  assign wb_reg     = rd_q;
  assign wb_data    = result_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue with a behavioural ALU on alu_out and an
// architectural register model predicting every writeback.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = '0;
  logic [4:0]  alu_opcode;
  logic [1:0]  alu_funct;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        illegal;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int total = 0;
  int passed = 0;
  logic [15:0] model_regs [8];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [15:0] rotl(input logic [15:0] a, input int n);
    logic [31:0] t;
    t = {a, a} >> (16 - n);
    return t[15:0];
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] a, input int n);
    logic [31:0] t;
    t = {a, a} >> n;
    return t[15:0];
  endfunction

  function automatic logic [15:0] alu_sem(input logic [4:0] op, input logic [1:0] f,
                                          input logic [15:0] a, input logic [15:0] b);
    int n;
    logic [15:0] r;
    n = int'(b[3:0]);
    r = '0;
    case (op)
      OP_ADDI:  r = a + b;
      OP_SUBI:  r = b - a;
      OP_XORI:  r = a ^ b;
      OP_ANDNI: r = a & ~b;
      OP_ROLI:  r = rotl(a, n);
      OP_SLLI:  r = a << n;
      OP_RORI:  r = rotr(a, n);
      OP_SRLI:  r = a >> n;
      OP_ARITH_R:
        case (f)
          2'd0: r = a + b;
          2'd1: r = b - a;
          2'd2: r = a ^ b;
          default: r = a & ~b;
        endcase
      OP_SHIFT_R:
        case (f)
          2'd0: r = rotl(a, n);
          2'd1: r = a << n;
          2'd2: r = rotr(a, n);
          default: r = a >> n;
        endcase
      OP_BTR: for (int i = 0; i < 16; i++) r[i] = a[15-i];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_out = alu_sem(alu_opcode, alu_funct, alu_ain, alu_bin);

  function automatic bit op_legal(input logic [4:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI,
                      OP_RORI, OP_SRLI, OP_BTR, OP_SHIFT_R, OP_ARITH_R};
  endfunction

  function automatic bit op_rfmt(input logic [4:0] op);
    return op inside {OP_BTR, OP_SHIFT_R, OP_ARITH_R};
  endfunction

  function automatic logic [15:0] model_bin(input logic [15:0] ins);
    logic [4:0] op;
    int v;
    op = ins[15:11];
    v  = int'(ins[4:0]);
    if (op inside {OP_ADDI, OP_SUBI}) return 16'((v >= 16) ? v - 32 : v);
    if (op inside {OP_XORI, OP_ANDNI}) return 16'(v);
    if (op inside {OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI}) return 16'(v % 16);
    if (op inside {OP_ARITH_R, OP_SHIFT_R}) return model_regs[ins[7:5]];
    return 16'h0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One complete transaction from handshake to idle, checked cycle by cycle.
  task automatic run_instr(input logic [15:0] ins, output logic [15:0] got);
    logic [4:0]  op;
    logic [1:0]  f;
    logic [2:0]  rd;
    logic [15:0] a, b, exp;
    int budget;
    budget = 0;
    while (!in_ready && budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    op  = ins[15:11];
    f   = (op inside {OP_ARITH_R, OP_SHIFT_R}) ? ins[1:0] : 2'b00;
    rd  = op_rfmt(op) ? ins[4:2] : ins[7:5];
    a   = model_regs[ins[10:8]];
    b   = model_bin(ins);
    exp = alu_sem(op, f, a, b);
    got = '0;
    in_valid = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    instr = 16'($urandom);
    if (!op_legal(op)) begin
      check("illegal_pulse", illegal, 1);
      check("illegal_no_wb", wb_valid, 0);
      check("illegal_ready", in_ready, 1);
      @(posedge clk); #1;
      check("illegal_drop", illegal, 0);
      check("illegal_no_wb2", wb_valid, 0);
      $display("instr %h illegal", ins);
      return;
    end
    in_valid = 1'($urandom_range(0, 1));
    check("issue_ready", in_ready, 0);
    check("issue_illegal", illegal, 0);
    check("issue_opcode", alu_opcode, op);
    check("issue_funct", alu_funct, f);
    check("issue_ain", alu_ain, a);
    check("issue_bin", alu_bin, b);
    check("issue_wb", wb_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("wb_valid", wb_valid, 1);
    check("wb_reg", wb_reg, rd);
    check("wb_data", wb_data, exp);
    check("wb_ready", in_ready, 0);
    got = wb_data;
    @(posedge clk); #1;
    model_regs[rd] = exp;
    check("idle_wb", wb_valid, 0);
    check("idle_ready", in_ready, 1);
    dbg_addr = rd;
    #1;
    check("dbg_after_wb", dbg_data, exp);
    $display("instr %h -> R%0d = %h", ins, rd, got);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];
  logic [4:0] legal_ops [11];
  logic [15:0] got;
  logic [15:0] seq [3];
  logic [15:0] seq_exp [3];

  initial begin
    vecs[0]  = '{16'h403D, 16'hFFFD};  // ADDI R1 = R0 + (-3)
    vecs[1]  = '{16'h505F, 16'h001F};  // XORI R2 = R0 ^ 0x1F
    vecs[2]  = '{16'hAA64, 16'h01F0};  // SLLI R3 = R2 << 4
    vecs[3]  = '{16'h4022, 16'h0002};  // ADDI R1 = 2
    vecs[4]  = '{16'h4047, 16'h0007};  // ADDI R2 = 7
    vecs[5]  = '{16'hD951, 16'h0005};  // SUB R4 = R2 - R1
    vecs[6]  = '{16'h40BF, 16'hFFFF};  // ADDI R5 = -1
    vecs[7]  = '{16'h40C1, 16'h0001};  // ADDI R6 = 1
    vecs[8]  = '{16'hDDDC, 16'h0000};  // ADD R7 = R5 + R6 wraps
    vecs[9]  = '{16'hC90C, 16'h4000};  // BTR R3 = rev(R1)
    vecs[10] = '{16'h4903, 16'h0001};  // SUBI R0 = 3 - R1
    legal_ops = '{OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI,
                  OP_RORI, OP_SRLI, OP_BTR, OP_SHIFT_R, OP_ARITH_R};
    for (int i = 0; i < 8; i++) model_regs[i] = '0;

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1);
    check("rst_wb", wb_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_wb_data", wb_data, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("rst_dbg", dbg_data, 0);
    end

    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i].ins, got);
      check("vec_data", got, vecs[i].exp);
    end

    // Back-to-back with in_valid held high: accepted every third cycle.
    seq = '{16'h4121, 16'h4121, 16'h5143};
    for (int k = 0; k < 3; k++) begin
      logic [4:0] op;
      op = seq[k][15:11];
      seq_exp[k] = alu_sem(op, 2'b00, model_regs[seq[k][10:8]], model_bin(seq[k]));
      model_regs[seq[k][7:5]] = seq_exp[k];
    end
    in_valid = 1'b1;
    instr = seq[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) in_valid = 1'b0;
      else instr = seq[k+1];
      check("b2b_issue_ready", in_ready, 0);
      @(posedge clk); #1;
      check("b2b_wb_ready", in_ready, 0);
      check("b2b_wb_valid", wb_valid, 1);
      check("b2b_wb_data", wb_data, seq_exp[k]);
      @(posedge clk); #1;
      check("b2b_idle_ready", in_ready, 1);
      check("b2b_idle_wb", wb_valid, 0);
      $display("b2b %0d instr %h -> %h", k, seq[k], seq_exp[k]);
    end

    run_instr(16'h0123, got);

    // Randomized stream including illegal opcodes.
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 7));
      else op = legal_ops[$urandom_range(0, 10)];
      run_instr({op, 11'($urandom)}, got);
    end

    // Reset during ISSUE of ADDI R5 aborts the write.
    in_valid = 1'b1;
    instr = 16'h40A3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_in_issue", in_ready, 0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    check("abort_ready", in_ready, 1);
    check("abort_wb", wb_valid, 0);
    dbg_addr = 3'd5;
    #1;
    check("abort_r5", dbg_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_no_wb", wb_valid, 0);
      check("abort_idle", in_ready, 1);
    end
    check("abort_r5_after", dbg_data, 0);
    $display("reset abort done");

    run_instr(16'h40A3, got);
    check("post_abort_r5", got, 16'h0003);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
